// File: rtl/zbus_ser.sv
// zbus serializer: one wide word in, 1..SN narrow beats out.
// zo_lst frames the word; zi_ack reloads on the last beat so words run back to back.
module zbus_ser #(
  parameter int BW  = 8,
  parameter int SN  = 4,
  parameter int SNL = $clog2(SN),
  parameter int ORD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zi_vld,
  input  logic [SN*BW-1:0] zi_bus,
  input  logic [SNL-1:0]   zi_len,
  output logic             zi_ack,
  output logic             zo_vld,
  output logic [BW-1:0]    zo_bus,
  output logic             zo_lst,
  output logic [SNL-1:0]   zo_cnt,
  input  logic             zo_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q;
  logic [SN*BW-1:0]   data_q;
  logic [SNL-1:0]     len_q;
  logic [SNL-1:0]     cnt_q;
  logic               busy;
  logic               zi_trn;
  logic               zo_trn;
  logic [SNL-1:0]     sel;
  logic [BW-1:0]      slc [SN];

  assign busy   = (state_q == SEND);
  assign zo_vld = busy;
  assign zo_cnt = cnt_q;
  assign zo_lst = busy & (cnt_q == len_q);
  assign zo_trn = zo_vld & zo_ack;
  assign zi_ack = ~rst & (~busy | (zo_trn & zo_lst));
  assign zi_trn = zi_vld & zi_ack;

  for (genvar g = 0; g < SN; g++) begin : g_slc
    assign slc[g] = data_q[g*BW +: BW];
  end

  // MSB-first walks down from the top used slice, so slice 0 is always last
  assign sel    = (ORD != 0) ? (len_q - cnt_q) : cnt_q;
  assign zo_bus = slc[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else if (zi_trn) begin
      state_q <= SEND;
      data_q  <= zi_bus;
      len_q   <= zi_len;
      cnt_q   <= '0;
    end else if (zo_trn) begin
      if (zo_lst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule
